// File: rtl/usb4_tx_pkg.sv
// Shared USB4 transmit-path definitions.
//   d_sel_e    : lane data-bus source select. The data bus transmit block decodes
//                the same encoding.
//   tx_state_e : ordered-set sequencer states. The encoding is exported as the
//                debug phase value.
//   DEF_*      : default ordered-set counts per phase and the default phase timeout.
//   state_to_dsel : maps a sequencer state to the bus select it drives.
package usb4_tx_pkg;

    typedef enum logic [3:0] {
        D_SLOS1 = 4'd0,
        D_SLOS2 = 4'd1,
        D_G3TS1 = 4'd2,
        D_G3TS2 = 4'd3,
        D_G4TS1 = 4'd4,
        D_G4TS2 = 4'd5,
        D_G4TS3 = 4'd6,
        D_G4TS4 = 4'd7,
        D_DATA  = 4'd8,
        D_IDLE  = 4'd9
    } d_sel_e;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StSlos1 = 4'd1,
        StSlos2 = 4'd2,
        StG3Ts1 = 4'd3,
        StG3Ts2 = 4'd4,
        StG4Ts1 = 4'd5,
        StG4Ts2 = 4'd6,
        StG4Ts3 = 4'd7,
        StG4Ts4 = 4'd8,
        StCl0   = 4'd9
    } tx_state_e;

    localparam int unsigned DEF_SLOS1_CNT   = 2;
    localparam int unsigned DEF_SLOS2_CNT   = 2;
    localparam int unsigned DEF_G3_TS1_CNT  = 16;
    localparam int unsigned DEF_G3_TS2_CNT  = 16;
    localparam int unsigned DEF_G4_TS_CNT   = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 65535;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic d_sel_e state_to_dsel(input tx_state_e s);
        case (s)
            StSlos1: return D_SLOS1;
            StSlos2: return D_SLOS2;
            StG3Ts1: return D_G3TS1;
            StG3Ts2: return D_G3TS2;
            StG4Ts1: return D_G4TS1;
            StG4Ts2: return D_G4TS2;
            StG4Ts3: return D_G4TS3;
            StG4Ts4: return D_G4TS4;
            StCl0:   return D_DATA;
            default: return D_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tx_phase_counter.sv
// Per-phase ordered-set and cycle counter for the ordered-set sequencer.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   i_clr           : phase entry; clears both counters and arms the stale-pulse discard
//   i_active        : high while in a training phase; counters advance only then
//   i_os_sent       : one pulse per ordered set completed by the transmit bus
//   i_target        : ordered-set count required by the current phase
//   o_cnt_done      : count is met, including a qualifying pulse in this cycle
//   o_timeout       : last cycle of the phase budget
module tx_phase_counter #(
    parameter int unsigned OS_W        = 5,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_active,
    input  logic            i_os_sent,
    input  logic [OS_W-1:0] i_target,
    output logic            o_cnt_done,
    output logic            o_timeout
);

    logic [OS_W-1:0]  r_os_cnt;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic             r_first;
    logic             w_valid;
    logic             w_at_target;

    // The transmit bus registers os_sent, so the pulse seen in the first cycle
    // of a phase still belongs to the previous phase.
    assign w_valid     = i_active & i_os_sent & ~r_first;
    assign w_at_target = (r_os_cnt == i_target);

    // Look ahead by one pulse so the exit lands on the edge that samples the final set.
    assign o_cnt_done = w_at_target | (w_valid & (r_os_cnt == (i_target - OS_W'(1))));
    assign o_timeout  = i_active & (r_cyc_cnt == CYC_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_os_cnt  <= '0;
            r_cyc_cnt <= '0;
            r_first   <= 1'b0;
        end else if (i_clr) begin
            r_os_cnt  <= '0;
            r_cyc_cnt <= '0;
            r_first   <= 1'b1;
        end else if (i_active) begin
            r_first <= 1'b0;
            if (w_valid && !w_at_target) begin
                r_os_cnt <= r_os_cnt + OS_W'(1);
            end
            if (!o_timeout) begin
                r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_os_sequencer.sv
// Ordered-set sequencer feeding the lane transmit data bus. Walks the Gen3
// (SLOS1, SLOS2, TS1, TS2) or Gen4 (TS1..TS4) training sequence, then hands the
// lanes to transport data (CL0). An abort or a phase timeout parks the lanes idle.
// Build option: TX_OS_SEQ_SKIP_SLOS_EN sends a Gen3 start straight to G3TS1,
// skipping both SLOS phases (fast link-up simulation).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_start           : single-cycle pulse, begins training from idle
//   i_gen4            : speed select sampled with an accepted start (1 = Gen4)
//   i_abort           : return to idle
//   i_rx_partner_ok   : partner's matching set seen; qualifies TS phase exits
//   i_os_sent         : one pulse per ordered set completed by the transmit bus
//   o_d_sel           : data bus select (d_sel_e encoding)
//   o_cl0_active      : high while the bus carries transport data
//   o_training_fail   : one-cycle pulse on phase timeout
//   o_phase           : current state encoding, for debug
module tx_os_sequencer
    import usb4_tx_pkg::*;
#(
    parameter int unsigned SLOS1_CNT   = DEF_SLOS1_CNT,
    parameter int unsigned SLOS2_CNT   = DEF_SLOS2_CNT,
    parameter int unsigned G3_TS1_CNT  = DEF_G3_TS1_CNT,
    parameter int unsigned G3_TS2_CNT  = DEF_G3_TS2_CNT,
    parameter int unsigned G4_TS_CNT   = DEF_G4_TS_CNT,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_gen4,
    input  logic       i_abort,
    input  logic       i_rx_partner_ok,
    input  logic       i_os_sent,
    output logic [3:0] o_d_sel,
    output logic       o_cl0_active,
    output logic       o_training_fail,
    output logic [3:0] o_phase
);

    localparam int unsigned MAX_CNT = max_u(max_u(max_u(SLOS1_CNT, SLOS2_CNT),
                                                  max_u(G3_TS1_CNT, G3_TS2_CNT)), G4_TS_CNT);
    localparam int unsigned OS_W    = $clog2(MAX_CNT + 1);
    localparam int unsigned CYC_W   = $clog2(TIMEOUT_CYC + 1);

`ifdef TX_OS_SEQ_SKIP_SLOS_EN
    localparam tx_state_e G3_ENTRY = StG3Ts1;
`else
    localparam tx_state_e G3_ENTRY = StSlos1;
`endif

    tx_state_e       r_state;
    tx_state_e       w_state_d;
    tx_state_e       w_next;
    d_sel_e          r_d_sel;
    logic            r_cl0;
    logic            r_fail;
    logic            w_fail;
    logic            w_train;
    logic            w_need_rx;
    logic            w_exit;
    logic            w_clr;
    logic            w_cnt_done;
    logic            w_timeout;
    logic [OS_W-1:0] w_target;

    // Per-phase count, rx qualification and successor. The speed chosen at start is
    // carried by the path itself (Gen3 and Gen4 phases are distinct states).
    always_comb begin
        w_target  = '0;
        w_need_rx = 1'b1;
        w_train   = 1'b1;
        w_next    = StCl0;
        case (r_state)
            StSlos1: begin
                w_target  = OS_W'(SLOS1_CNT);
                w_need_rx = 1'b0;
                w_next    = StSlos2;
            end
            StSlos2: begin
                w_target  = OS_W'(SLOS2_CNT);
                w_need_rx = 1'b0;
                w_next    = StG3Ts1;
            end
            StG3Ts1: begin
                w_target = OS_W'(G3_TS1_CNT);
                w_next   = StG3Ts2;
            end
            StG3Ts2: begin
                w_target = OS_W'(G3_TS2_CNT);
                w_next   = StCl0;
            end
            StG4Ts1: begin
                w_target = OS_W'(G4_TS_CNT);
                w_next   = StG4Ts2;
            end
            StG4Ts2: begin
                w_target = OS_W'(G4_TS_CNT);
                w_next   = StG4Ts3;
            end
            StG4Ts3: begin
                w_target = OS_W'(G4_TS_CNT);
                w_next   = StG4Ts4;
            end
            StG4Ts4: begin
                w_target = OS_W'(G4_TS_CNT);
                w_next   = StCl0;
            end
            default: begin
                w_train = 1'b0;
                w_next  = StIdle;
            end
        endcase
    end

    assign w_exit = w_train & w_cnt_done & (i_rx_partner_ok | ~w_need_rx);

    // Priority: abort > exit > timeout. CL0 holds until abort.
    always_comb begin
        w_state_d = r_state;
        w_fail    = 1'b0;
        if (i_abort) begin
            w_state_d = StIdle;
        end else if (r_state == StIdle) begin
            if (i_start) begin
                w_state_d = i_gen4 ? StG4Ts1 : G3_ENTRY;
            end
        end else if (w_train) begin
            if (w_exit) begin
                w_state_d = w_next;
            end else if (w_timeout) begin
                w_state_d = StIdle;
                w_fail    = 1'b1;
            end
        end
    end

    assign w_clr = (w_state_d != r_state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_d_sel <= D_IDLE;
            r_cl0   <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_d_sel <= state_to_dsel(w_state_d);
            r_cl0   <= (w_state_d == StCl0);
            r_fail  <= w_fail;
        end
    end

    tx_phase_counter #(
        .OS_W        (OS_W),
        .CYC_W       (CYC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_active   (w_train),
        .i_os_sent  (i_os_sent),
        .i_target   (w_target),
        .o_cnt_done (w_cnt_done),
        .o_timeout  (w_timeout)
    );

    assign o_d_sel         = r_d_sel;
    assign o_cl0_active    = r_cl0;
    assign o_training_fail = r_fail;
    assign o_phase         = r_state;

endmodule

// File: tb/tb_tx_os_sequencer.sv
// Bench for tx_os_sequencer: directed scenarios plus a randomized run, every
// cycle compared against a phase-list reference model.
module tb_tx_os_sequencer;

    localparam int unsigned C_SLOS1 = 2;
    localparam int unsigned C_SLOS2 = 2;
    localparam int unsigned C_G3TS1 = 4;
    localparam int unsigned C_G3TS2 = 4;
    localparam int unsigned C_G4    = 3;
    localparam int unsigned C_TO    = 100;
`ifdef TX_OS_SEQ_SKIP_SLOS_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       gen4 = 1'b0;
    logic       abort = 1'b0;
    logic       rx = 1'b0;
    logic       os = 1'b0;
    logic [3:0] d_sel;
    logic [3:0] phase;
    logic       cl0;
    logic       fail;

    always #5 clk = ~clk;

    tx_os_sequencer #(
        .SLOS1_CNT   (C_SLOS1),
        .SLOS2_CNT   (C_SLOS2),
        .G3_TS1_CNT  (C_G3TS1),
        .G3_TS2_CNT  (C_G3TS2),
        .G4_TS_CNT   (C_G4),
        .TIMEOUT_CYC (C_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (start),
        .i_gen4          (gen4),
        .i_abort         (abort),
        .i_rx_partner_ok (rx),
        .i_os_sent       (os),
        .o_d_sel         (d_sel),
        .o_cl0_active    (cl0),
        .o_training_fail (fail),
        .o_phase         (phase)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: position in a 4-entry phase list (-1 idle, 4 data), pulses counted
    // and cycles elapsed in the current phase.
    int m_pos = -1;
    bit m_g4 = 1'b0;
    int m_pulses = 0;
    int m_age = 0;
    bit m_fail = 1'b0;
    logic [3:0] log_q[$];

    function automatic int need_of(input int pos, input bit g4_path);
        if (g4_path) return C_G4;
        case (pos)
            0: return C_SLOS1;
            1: return C_SLOS2;
            2: return C_G3TS1;
            default: return C_G3TS2;
        endcase
    endfunction

    function automatic logic [31:0] exp_dsel();
        if (m_pos < 0) return 9;
        if (m_pos == 4) return 8;
        return m_g4 ? 4 + m_pos : m_pos;
    endfunction

    function automatic logic [31:0] exp_phase();
        if (m_pos < 0) return 0;
        if (m_pos == 4) return 9;
        return m_g4 ? 5 + m_pos : 1 + m_pos;
    endfunction

    task automatic model_reset();
        m_pos = -1;
        m_pulses = 0;
        m_age = 0;
        m_fail = 1'b0;
    endtask

    task automatic model_step();
        int need;
        bit slos;
        m_fail = 1'b0;
        if (abort) begin
            m_pos = -1;
            m_pulses = 0;
            m_age = 0;
        end else if (m_pos < 0) begin
            if (start) begin
                m_g4 = gen4;
                m_pos = (gen4 || !SKIP) ? 0 : 2;
                m_pulses = 0;
                m_age = 0;
            end
        end else if (m_pos < 4) begin
            need = need_of(m_pos, m_g4);
            slos = !m_g4 && (m_pos < 2);
            if (os && (m_age > 0) && (m_pulses < need)) m_pulses++;
            if ((m_pulses == need) && (slos || rx)) begin
                m_pos++;
                m_pulses = 0;
                m_age = 0;
            end else if (m_age == C_TO - 1) begin
                m_pos = -1;
                m_fail = 1'b1;
                m_pulses = 0;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_model();
        check("d_sel", d_sel, exp_dsel());
        check("phase", phase, exp_phase());
        check("cl0_active", cl0, (m_pos == 4));
        check("training_fail", fail, m_fail);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        if (log_q.size() == 0 || log_q[$] !== d_sel) log_q.push_back(d_sel);
    endtask

    task automatic run_until_dsel(input logic [3:0] want, input int period, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (d_sel === want) break;
            os = ((i % period) == period - 1);
            tick();
        end
        os = 1'b0;
        check("reach_dsel", d_sel, want);
    endtask

    task automatic pulse_start(input logic g);
        gen4 = g;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq[$];
        int n;

        // Reset
        #1 rst = 1'b0;
        #2;
        model_reset();
        check_model();
        tick();
        tick();
        @(negedge clk) rst = 1'b1;
        tick();

        // Gen3 full sequence
        rx = 1'b1;
        log_q.delete();
        log_q.push_back(d_sel);
        pulse_start(1'b0);
        run_until_dsel(4'd8, 8, 300);
        if (SKIP) exp_seq = '{4'd9, 4'd2, 4'd3, 4'd8};
        else exp_seq = '{4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
        check("g3_seq_len", log_q.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i < log_q.size()) check("g3_seq", log_q[i], exp_seq[i]);
        end
        check("cl0_with_data", cl0, 1'b1);
        os = 1'b1;
        tick();
        os = 1'b0;
        check("cl0_ignores_os", d_sel, 4'd8);

        // Abort in CL0
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cl0_dsel", d_sel, 4'd9);
        check("abort_cl0_cl0", cl0, 1'b0);
        check("abort_cl0_fail", fail, 1'b0);

        // Gen4, rx low throughout G4TS2
        rx = 1'b1;
        pulse_start(1'b1);
        run_until_dsel(4'd5, 4, 100);
        rx = 1'b0;
        for (int i = 0; i < 24; i++) begin
            os = ((i % 4) == 3);
            tick();
        end
        os = 1'b0;
        check("g4ts2_hold", d_sel, 4'd5);
        rx = 1'b1;
        tick();
        check("g4ts2_rx_exit", d_sel, 4'd6);
        run_until_dsel(4'd7, 4, 100);
        // Abort coinciding with the final G4TS4 set
        tick();
        os = 1'b1; tick();
        os = 1'b0; tick();
        os = 1'b1; tick();
        os = 1'b0; tick();
        os = 1'b1; abort = 1'b1; tick();
        os = 1'b0; abort = 1'b0;
        check("abort_final_dsel", d_sel, 4'd9);
        check("abort_final_cl0", cl0, 1'b0);
        check("abort_final_fail", fail, 1'b0);
        tick();
        tick();
        check("abort_final_stay", d_sel, 4'd9);

        // Stale pulse in first cycle of SLOS2
        if (!SKIP) begin
            pulse_start(1'b0);
            tick();
            os = 1'b1; tick();
            os = 1'b0; tick();
            os = 1'b1; tick();
            check("slos1_exit", d_sel, 4'd1);
            tick();
            os = 1'b0; tick();
            os = 1'b1; tick();
            check("stale_ignored", d_sel, 4'd1);
            os = 1'b0; tick();
            os = 1'b1; tick();
            os = 1'b0;
            check("slos2_exit", d_sel, 4'd2);
            abort = 1'b1; tick(); abort = 1'b0;
        end

        // Timeout in G3TS1
        pulse_start(1'b0);
        run_until_dsel(4'd2, 8, 100);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            n++;
            if (fail === 1'b1) break;
        end
        check("timeout_cycle", n, C_TO);
        check("timeout_dsel", d_sel, 4'd9);
        tick();
        check("timeout_single", fail, 1'b0);
        pulse_start(1'b0);
        check("restart_dsel", d_sel, SKIP ? 4'd2 : 4'd0);
        abort = 1'b1; tick(); abort = 1'b0;

        // Reset mid-G3TS2
        pulse_start(1'b0);
        run_until_dsel(4'd3, 8, 300);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_dsel", d_sel, 4'd9);
        check("rst_phase", phase, 4'd0);
        check("rst_cl0", cl0, 1'b0);
        check("rst_fail", fail, 1'b0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            gen4 = $urandom_range(0, 1) == 1;
            abort = ($urandom_range(0, 149) == 0);
            os = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) rx = ~rx;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        os = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_os_sequencer.md
Name: tx_os_sequencer

Overview:
- Ordered-set sequencer directly upstream of the lane transmit data bus. Drives its 4-bit d_sel select and consumes its os_sent pulse.
- Walks the Gen3 sequence (SLOS1, SLOS2, TS1, TS2) or the Gen4 sequence (TS1, TS2, TS3, TS4), counting transmitted ordered sets per phase.
- On completion hands the lanes to transport data (CL0). On abort or timeout it parks the lanes idle.

Parameters:
- SLOS1_CNT, 2: SLOS1 sets sent before leaving the phase.
- SLOS2_CNT, 2: SLOS2 sets sent before leaving the phase.
- G3_TS1_CNT, 16: Gen3 TS1 sets required.
- G3_TS2_CNT, 16: Gen3 TS2 sets required.
- G4_TS_CNT, 16: sets required in each Gen4 TS1..TS4 phase.
- TIMEOUT_CYC, 65535: clk cycles allowed per phase before failure.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  single-cycle pulse; begins training from IDLE
- gen4  in  1  speed select, sampled only on an accepted start: 1 = Gen4, 0 = Gen3
- abort  in  1  level/pulse; return to IDLE
- rx_partner_ok  in  1  receive side has seen the partner's matching set; qualifies exit from TS phases
- os_sent  in  1  one pulse per ordered set completed by the transmit bus
- d_sel  out  4  select: 0 SLOS1, 1 SLOS2, 2 G3TS1, 3 G3TS2, 4 G4TS1, 5 G4TS2, 6 G4TS3, 7 G4TS4, 8 data, 9 idle
- cl0_active  out  1  high while d_sel = 8
- training_fail  out  1  one-cycle pulse on timeout
- phase  out  4  current state encoding, for debug

Behaviour:
- Reset: state IDLE, d_sel = 9, cl0_active = 0, training_fail = 0, phase = 0, all counters 0.
- States: IDLE, SLOS1, SLOS2, G3TS1, G3TS2, G4TS1, G4TS2, G4TS3, G4TS4, CL0.
- phase encoding: IDLE = 0, then 1..9 in the order listed.
- d_sel, cl0_active and training_fail are registered. d_sel reflects the new state on the edge that enters it, so d_sel changes one cycle after the causing input.
- IDLE + start:
  - gen4 = 0: latch gen4, go to SLOS1.
  - gen4 = 1: latch gen4, go to G4TS1.
- start outside IDLE is ignored.
- Per phase:
  - os_cnt and cyc_cnt clear on entry.
  - os_cnt increments on each os_sent and saturates at the phase count.
  - The os_sent pulse sampled in the first cycle after entry is discarded, because the transmit bus registers os_sent and that pulse belongs to the previous phase.
- Exit condition: os_cnt == count, and additionally rx_partner_ok = 1 for TS phases. SLOS phases need no rx qualification.
- Exit order:
  - Gen3: SLOS1 -> SLOS2 -> G3TS1 -> G3TS2 -> CL0.
  - Gen4: G4TS1 -> G4TS2 -> G4TS3 -> G4TS4 -> CL0.
- The phase count may already be met while rx_partner_ok is low. In that case the phase stays and keeps sending.
- Timeout:
  - cyc_cnt increments every cycle in a training phase.
  - At cyc_cnt == TIMEOUT_CYC-1 without an exit: training_fail pulses, d_sel = 9, state goes to IDLE.
- CL0: d_sel = 8 and cl0_active = 1. Held until abort. os_sent is ignored.
- abort in any state: next cycle IDLE, d_sel = 9, cl0_active = 0, no training_fail pulse.
- Priority: abort > exit > timeout. abort and start in the same cycle in IDLE stays IDLE.
- Widths:
  - os_cnt is $clog2(max count + 1) bits.
  - cyc_cnt is $clog2(TIMEOUT_CYC + 1) bits.
  - All counts are >= 1. A count of 1 exits on the first valid os_sent.
- Asserting rst mid-phase returns immediately to the reset values.

Optional Feature:
- TX_OS_SEQ_SKIP_SLOS_EN defined: Gen3 start goes directly to G3TS1, and SLOS1/SLOS2 are unreachable. Used for fast link-up simulation.
- Undefined: full Gen3 sequence as above.
- The Gen4 path is unaffected either way.

Decomposition:
- Shared package usb4_tx_pkg holds:
  - the d_sel encoding as a typedef enum logic [3:0] (D_SLOS1..D_IDLE);
  - the state enum;
  - the default phase-count constants.
- The data bus transmit block imports the same d_sel enum.
- One natural sub-module: tx_phase_counter. It owns os_cnt, cyc_cnt and the first-cycle discard, and outputs cnt_done and timeout.
- The FSM stays in the top module.

Test Plan:
- Gen3, counts 2/2/4/4, rx_partner_ok = 1, os_sent every 8 cycles:
  - d_sel steps 9 -> 0 -> 1 -> 2 -> 3 -> 8.
  - Each phase exits on the 2nd / 2nd / 4th / 4th valid pulse.
  - cl0_active rises with d_sel = 8.
- Gen4, G4_TS_CNT = 3, rx_partner_ok = 0 throughout G4TS2:
  - d_sel stays 5 beyond 3 pulses.
  - Raising rx_partner_ok moves to d_sel 6 on the next edge.
- Stale pulse: os_sent asserted in the first cycle after SLOS1 -> SLOS2 entry is not counted; SLOS2 needs 2 further pulses.
- TIMEOUT_CYC = 100, no os_sent in G3TS1:
  - training_fail is a single pulse at cycle 100 of the phase.
  - d_sel returns to 9.
  - A subsequent start restarts from SLOS1.
- abort in CL0, and abort coinciding with the final os_sent of G4TS4:
  - Both return to IDLE with d_sel = 9.
  - No CL0 entry and no training_fail.
- With TX_OS_SEQ_SKIP_SLOS_EN: Gen3 start -> d_sel 2 one cycle later. Reset asserted mid-G3TS2 -> d_sel = 9 immediately.
